imem_loader: RTL and testbench

//  Write-side companion to the byte-addressed instruction memory: accepts a byte stream
//  (e.g. from a UART RX or debug port) and writes big-endian 32-bit words into the

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/imem_byte_packer.sv | 46 ++++
 rtl/imem_loader.sv | 173 +++++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// Built with or without IMEM_LOADER_CHECKSUM_EN; the state list always includes CHK.
package imem_loader_pkg;

    localparam int MEM_WIDTH  = 8;
    localparam int WORD_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_LOAD = 3'd3,
        ST_CHK  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream MSB-first into 32-bit words; word_vld_o is a registered one-cycle strobe.
// Latency: word appears the cycle after its 4th byte. No backpressure; partial word held across gaps.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic                  byte_vld_i,
    input  logic [MEM_WIDTH-1:0]  byte_dat_i,
    output logic                  word_vld_o,
    output logic [WORD_WIDTH-1:0] word_dat_o
);

    logic [23:0]           sr_q;
    logic [1:0]            idx_q;
    logic                  word_vld_q;
    logic [WORD_WIDTH-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q       <= '0;
            idx_q      <= '0;
            word_vld_q <= 1'b0;
            word_q     <= '0;
        end else begin
            word_vld_q <= 1'b0;
            if (clear_i) begin
                sr_q  <= '0;
                idx_q <= '0;
            end else if (byte_vld_i) begin
                idx_q <= idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    word_q     <= {sr_q, byte_dat_i};
                    word_vld_q <= 1'b1;
                end else begin
                    sr_q <= {sr_q[15:0], byte_dat_i};
                end
            end
        end
    end

    assign word_vld_o = word_vld_q;
    assign word_dat_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as big-endian words (opt. IMEM_LOADER_CHECKSUM_EN).
// Latency: write one cycle after a word's 4th byte; done the cycle after the last write (or after the checksum byte).
// Backpressure: in_ready only in header/payload/checksum phases; full-rate payload streaming never stalls.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [MEM_WIDTH-1:0]  in_data_i,
    output logic                  in_ready_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [WORD_WIDTH-1:0] mem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [LEN_WIDTH-1:0]  word_count_o
);

    localparam int MAX_WORDS = MEM_DEPTH / 4 - BASE_ADDR / 4;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   wc_q, wc_d;
    logic                   done_q, done_d;
    logic                   pk_clear;
    logic                   pk_vld;
    logic [WORD_WIDTH-1:0]  pk_word;
    logic                   accept;
    logic [LEN_WIDTH:0]     words_in;
    logic [LEN_WIDTH-1:0]   hdr_len;
    logic                   last_write;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [MEM_WIDTH-1:0]   csum_q, csum_d;
`endif

    // Words fully received: already written plus the one being written this cycle.
    assign words_in   = {1'b0, wc_q} + {{LEN_WIDTH{1'b0}}, pk_vld};
    assign hdr_len    = {len_q[15:8], in_data_i};
    assign last_write = pk_vld && ((wc_q + 16'd1) == len_q);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        in_ready_o = 1'b0;
        case (state_q)
            ST_HDR0, ST_HDR1: in_ready_o = 1'b1;
            ST_LOAD:          in_ready_o = (words_in < {1'b0, len_q});
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK:           in_ready_o = 1'b1;
`endif
            default:          in_ready_o = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wc_d     = wc_q;
        done_d   = 1'b0;
        pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        if (pk_vld) begin
            wc_d = wc_q + 16'd1;
        end
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_i) begin
                    state_d  = ST_HDR0;
                    len_d    = '0;
                    wc_d     = '0;
                    pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d   = '0;
`endif
                end
            end
            ST_HDR0: begin
                if (accept) begin
                    len_d[15:8] = in_data_i;
                    state_d     = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    len_d = hdr_len;
                    if (hdr_len == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if ({16'd0, hdr_len} > 32'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum_d = csum_q ^ in_data_i;
                end
                if (last_write) begin
                    state_d = ST_CHK;
                end
`else
                if (last_write) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    if (in_data_i == csum_q) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            wc_q    <= '0;
            done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wc_q    <= wc_d;
            done_q  <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (pk_clear),
        .byte_vld_i (accept && (state_q == ST_LOAD)),
        .byte_dat_i (in_data_i),
        .word_vld_o (pk_vld),
        .word_dat_o (pk_word)
    );

    assign mem_we_o     = pk_vld;
    assign mem_wdata_o  = pk_word;
    assign mem_addr_o   = 32'(BASE_ADDR) + {14'd0, wc_q, 2'b00};
    assign busy_o       = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                          (state_q == ST_LOAD) || (state_q == ST_CHK);
    assign done_o       = done_q;
    assign err_o        = (state_q == ST_ERR);
    assign word_count_o = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand-written corner cases, randomized loads vs. a byte-level model.
module tb_imem_loader;

    localparam int MEM_DEPTH = 4096;
    localparam int MAXW      = MEM_DEPTH / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_ready_o, mem_we_o, busy_o, done_o, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [15:0] word_count_o;

    imem_loader #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .in_valid_i   (in_valid_i),
        .in_data_i    (in_data_i),
        .in_ready_o   (in_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap_at;
        int          gap_len;
        int          start_at;
        logic        exp_err;
        int          exp_done;
        int          exp_words;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  pay_q[$];
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          done_cnt = 0;
    int          gap_writes = 0;
    int          stalls = 0;
    logic        in_gap = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        bad_chk = 1'b0;
`endif

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we_o) begin
                cap_addr.push_back(mem_addr_o);
                cap_data.push_back(mem_wdata_o);
                if (in_gap) gap_writes++;
            end
            if (done_o) done_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b, input bit payload);
        int waited = 0;
        in_valid_i = 1'b1;
        in_data_i  = b;
        while (!in_ready_o && waited < 50) begin
            @(negedge clk);
            waited++;
            if (payload) stalls++;
        end
        chk("byte_accept", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] len, input int gap_at, input int gap_len, input int start_at);
        logic [7:0] cs = 8'h00;
        cap_addr.delete();
        cap_data.delete();
        done_cnt   = 0;
        gap_writes = 0;
        stalls     = 0;
        pulse_start();
        chk("busy_after_start", {31'd0, busy_o}, 32'd1);
        chk("err_cleared_by_start", {31'd0, err_o}, 32'd0);
        send_byte(len[15:8], 1'b0);
        send_byte(len[7:0], 1'b0);
        if (len != 16'd0 && int'(len) <= MAXW) begin
            for (int i = 0; i < pay_q.size(); i++) begin
                if (i == gap_at) begin
                    in_valid_i = 1'b0;
                    in_gap = (gap_at % 4) != 0;
                    repeat (gap_len) @(negedge clk);
                    in_gap = 1'b0;
                end
                if (i == start_at) start_i = 1'b1;
                send_byte(pay_q[i], 1'b1);
                start_i = 1'b0;
                cs ^= pay_q[i];
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(cs ^ {7'd0, bad_chk}, 1'b0);
`else
            chk("ready_low_after_payload", {31'd0, in_ready_o}, 32'd0);
`endif
        end
        in_valid_i = 1'b0;
        for (int k = 0; k < 40 && done_cnt == 0 && !err_o; k++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    // Expected writes come straight from the byte list: word i = bytes 4i..4i+3, MSB first, at byte address 4i.
    task automatic check_load(input string name, input logic exp_err, input int exp_done, input int exp_words);
        chk({name, "_nwrites"}, cap_addr.size(), exp_words);
        for (int i = 0; i < cap_addr.size() && i < exp_words; i++) begin
            chk({name, "_addr"}, cap_addr[i], 32'(4 * i));
            chk({name, "_data"}, cap_data[i],
                {pay_q[4*i], pay_q[4*i+1], pay_q[4*i+2], pay_q[4*i+3]});
        end
        chk({name, "_done"}, done_cnt, exp_done);
        chk({name, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
        chk({name, "_word_count"}, {16'd0, word_count_o}, exp_words);
        chk({name, "_busy_end"}, {31'd0, busy_o}, 32'd0);
        chk({name, "_stalls"}, stalls, 0);
        chk({name, "_gap_writes"}, gap_writes, 0);
        if (exp_err) chk({name, "_ready_in_err"}, {31'd0, in_ready_o}, 32'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_in_ready"}, {31'd0, in_ready_o}, 32'd0);
        chk({name, "_mem_we"}, {31'd0, mem_we_o}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({name, "_done"}, {31'd0, done_o}, 32'd0);
        chk({name, "_err"}, {31'd0, err_o}, 32'd0);
        chk({name, "_word_count"}, {16'd0, word_count_o}, 32'd0);
    endtask

    task automatic fill_words(input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w;
        pay_q.delete();
        for (int k = 0; k < n; k++) begin
            w = (k == 0) ? w0 : (k == 1) ? w1 : $urandom;
            pay_q.push_back(w[31:24]);
            pay_q.push_back(w[23:16]);
            pay_q.push_back(w[15:8]);
            pay_q.push_back(w[7:0]);
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{16'h0002, 32'h13000093, 32'h0010006F, -1, 0, -1, 1'b0, 1, 2};
        vecs[1] = '{16'h0002, 32'h13000093, 32'h0010006F,  2, 3, -1, 1'b0, 1, 2};
        vecs[2] = '{16'h0000, 32'h0,        32'h0,        -1, 0, -1, 1'b0, 1, 0};
        vecs[3] = '{16'h0401, 32'h0,        32'h0,        -1, 0, -1, 1'b1, 0, 0};
        vecs[4] = '{16'h0002, 32'hCAFEF00D, 32'h12345678, -1, 0,  5, 1'b0, 1, 2};
        vecs[5] = '{16'h0400, 32'hA5A5A5A5, 32'h5A5A5A5A,  9, 2, -1, 1'b0, 1, 1024};
        vecs[6] = '{16'hFFFF, 32'h0,        32'h0,        -1, 0, -1, 1'b1, 0, 0};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            fill_words((vecs[v].exp_err) ? 0 : int'(vecs[v].len), vecs[v].w0, vecs[v].w1);
            do_load(vecs[v].len, vecs[v].gap_at, vecs[v].gap_len, vecs[v].start_at);
            check_load($sformatf("vec%0d", v), vecs[v].exp_err, vecs[v].exp_done, vecs[v].exp_words);
        end

        // Reset in the middle of the second word, then a fresh one-word load.
        fill_words(2, 32'h11223344, 32'h55667788);
        cap_addr.delete();
        cap_data.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(pay_q[i], 1'b1);
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_writes", cap_addr.size(), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        do_load(16'h0001, -1, 0, -1);
        check_load("rst_reload", 1'b0, 1, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        bad_chk = 1'b0;
        do_load(16'h0001, -1, 0, -1);
        check_load("chk_ok", 1'b0, 1, 1);
        bad_chk = 1'b1;
        do_load(16'h0001, -1, 0, -1);
        check_load("chk_bad", 1'b1, 0, 1);
        bad_chk = 1'b0;
`endif

        for (int r = 0; r < 25; r++) begin
            logic [15:0] len;
            logic        e_err;
            int          e_done, e_words, g_at, s_at;
            if ($urandom_range(0, 9) == 0) len = 16'(MAXW + 1 + $urandom_range(0, 100));
            else                           len = 16'($urandom_range(1, 6));
            e_err   = int'(len) > MAXW;
            e_done  = e_err ? 0 : 1;
            e_words = e_err ? 0 : int'(len);
            pay_q.delete();
            for (int b = 0; b < 4 * e_words; b++) pay_q.push_back(8'($urandom));
            g_at = (e_words > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * e_words - 1)) : -1;
            s_at = (e_words > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4 * e_words - 1)) : -1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad_chk = !e_err && ($urandom_range(0, 3) == 0);
            if (bad_chk) begin
                e_err  = 1'b1;
                e_done = 0;
            end
`endif
            do_load(len, g_at, int'($urandom_range(1, 4)), s_at);
            check_load($sformatf("rand%0d", r), e_err, e_done, e_words);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
